// File: rtl/zigzag_pkg.sv
// Shared tables and helpers for the 8x8 coefficient reorder buffer.
// ZZ maps zigzag index to raster index; IZZ is its inverse.
package zigzag_pkg;

  typedef enum logic [1:0] {
    MODE_ZZ2ROW = 2'd0,
    MODE_ZZ2COL = 2'd1,
    MODE_ROW2ZZ = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  localparam logic [5:0] ZZ [0:63] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };

  localparam logic [5:0] IZZ [0:63] = '{
     0,  1,  5,  6, 14, 15, 27, 28,  2,  4,  7, 13, 16, 26, 29, 42,
     3,  8, 12, 17, 25, 30, 41, 43,  9, 11, 18, 24, 31, 40, 44, 53,
    10, 19, 23, 32, 39, 45, 52, 54, 20, 22, 33, 38, 46, 51, 55, 60,
    21, 34, 37, 47, 50, 56, 59, 61, 35, 36, 48, 49, 57, 58, 62, 63
  };

  function automatic logic [5:0] transpose6(input logic [5:0] p);
    return {p[2:0], p[5:3]};
  endfunction

  // Output position of input sample k under the given reorder mode.
  function automatic logic [5:0] out_pos(input mode_e m, input logic [5:0] k);
    case (m)
      MODE_ZZ2COL: return transpose6(ZZ[k]);
      MODE_ROW2ZZ: return IZZ[k];
      default:     return ZZ[k];
    endcase
  endfunction

endpackage

// File: rtl/zigzag_matrix_buf_ram.sv
// Simple dual-port bank RAM: one write port, one registered read port.
module zz_bank_ram #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 256
) (
  input  logic                     r_sysclk,
  input  logic                     r_srst,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [DATA_W-1:0]        i_wdata,
  input  logic                     i_re,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [DATA_W-1:0]        o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge r_sysclk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge r_sysclk or posedge r_srst) begin
    if (r_srst)    o_rdata <= '0;
    else if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/zigzag_matrix_buf.sv
// Multi-block 8x8 coefficient reorder buffer: samples are scattered to their
// output position on write and streamed out PX_OUT lanes per read beat.
module zigzag_matrix_buf
  import zigzag_pkg::*;
#(
  parameter int DATA_W     = 12,
  parameter int NUM_MATRIX = 4,
  parameter int PX_OUT     = 1
) (
  input  logic                     r_sysclk,
  input  logic                     r_srst,
  input  logic [1:0]               i_mode,
  input  logic                     i_we,
  input  logic [DATA_W-1:0]        i_data,
  output logic                     o_full,
  input  logic                     i_re,
  output logic                     o_nempty,
  output logic                     o_valid,
  output logic [PX_OUT*DATA_W-1:0] o_md,
  output logic                     o_sob,
  output logic                     o_eob,
  output logic [1:0]               o_mode
);

  localparam int SW    = $clog2(NUM_MATRIX);
  localparam int BEATS = 64 / PX_OUT;
  localparam int BW    = $clog2(BEATS);
  localparam int AW    = SW + BW;
  localparam int CW    = SW + 1;

  logic [5:0]    r_wcnt;
  logic [SW-1:0] r_wslot;
  logic [BW-1:0] r_rcnt;
  logic [SW-1:0] r_rslot;
  logic [CW-1:0] r_count;
  mode_e         r_slot_mode [NUM_MATRIX];

  mode_e             w_in_mode, w_wmode;
  logic [5:0]        w_pos;
  logic              w_wacc, w_racc, w_wdone, w_rdone;
  logic [CW-1:0]     w_count_nxt;
  logic [AW-1:0]     w_waddr, w_raddr;
  logic [PX_OUT-1:0] w_bank_we;

  always_comb begin
    w_in_mode   = (i_mode == MODE_RSVD) ? MODE_ZZ2ROW : mode_e'(i_mode);
    // First sample of a block uses the live mode; the rest use the captured one.
    w_wmode     = (r_wcnt == '0) ? w_in_mode : r_slot_mode[r_wslot];
    w_pos       = out_pos(w_wmode, r_wcnt);
    w_wacc      = i_we && !o_full;
    w_racc      = i_re && o_nempty;
    w_wdone     = w_wacc && (r_wcnt == 6'd63);
    w_rdone     = w_racc && (r_rcnt == BW'(BEATS - 1));
    w_count_nxt = r_count + CW'(w_wdone) - CW'(w_rdone);
    w_waddr     = {r_wslot, BW'(32'(w_pos) / PX_OUT)};
    w_raddr     = {r_rslot, r_rcnt};
    w_bank_we   = '0;
    for (int unsigned b = 0; b < PX_OUT; b++) begin
      w_bank_we[b] = w_wacc && ((32'(w_pos) % PX_OUT) == b);
    end
  end

  always_ff @(posedge r_sysclk or posedge r_srst) begin
    if (r_srst) begin
      r_wcnt   <= '0;
      r_wslot  <= '0;
      r_rcnt   <= '0;
      r_rslot  <= '0;
      r_count  <= '0;
      o_full   <= 1'b0;
      o_nempty <= 1'b0;
      o_valid  <= 1'b0;
      o_sob    <= 1'b0;
      o_eob    <= 1'b0;
      o_mode   <= '0;
      for (int unsigned s = 0; s < NUM_MATRIX; s++) r_slot_mode[s] <= MODE_ZZ2ROW;
    end else begin
      if (w_wacc) begin
        r_wcnt <= r_wcnt + 6'd1;
        if (r_wcnt == '0) r_slot_mode[r_wslot] <= w_in_mode;
        if (w_wdone)      r_wslot <= r_wslot + SW'(1);
      end
      if (w_racc) begin
        r_rcnt <= r_rcnt + BW'(1);
        o_mode <= r_slot_mode[r_rslot];
        if (w_rdone) r_rslot <= r_rslot + SW'(1);
      end
      r_count  <= w_count_nxt;
      o_full   <= (w_count_nxt == CW'(NUM_MATRIX));
      o_nempty <= (w_count_nxt != '0);
      o_valid  <= w_racc;
      o_sob    <= w_racc && (r_rcnt == '0);
      o_eob    <= w_rdone;
    end
  end

  for (genvar b = 0; b < PX_OUT; b++) begin : g_bank
    zz_bank_ram #(
      .DATA_W(DATA_W),
      .DEPTH (NUM_MATRIX * BEATS)
    ) u_ram (
      .r_sysclk(r_sysclk),
      .r_srst  (r_srst),
      .i_we    (w_bank_we[b]),
      .i_waddr (w_waddr),
      .i_wdata (i_data),
      .i_re    (w_racc),
      .i_raddr (w_raddr),
      .o_rdata (o_md[b*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_zigzag_matrix_buf.sv
// Bench for zigzag_matrix_buf: PX_OUT=1 and PX_OUT=4 instances share the write
// stream and are checked every cycle against a block-queue reference model.
module tb_zigzag_matrix_buf;

  localparam int DW = 12;
  localparam int NM = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    mode = '0;
  logic          we = 1'b0;
  logic [DW-1:0] din = '0;
  logic          re1 = 1'b0, re4 = 1'b0;

  logic            full1, nempty1, valid1, sob1, eob1;
  logic [DW-1:0]   md1;
  logic [1:0]      omode1;
  logic            full4, nempty4, valid4, sob4, eob4;
  logic [4*DW-1:0] md4;
  logic [1:0]      omode4;

  always #5 clk = ~clk;

  zigzag_matrix_buf #(.DATA_W(DW), .NUM_MATRIX(NM), .PX_OUT(1)) dut1 (
    .r_sysclk(clk), .r_srst(rst), .i_mode(mode), .i_we(we), .i_data(din),
    .o_full(full1), .i_re(re1), .o_nempty(nempty1), .o_valid(valid1),
    .o_md(md1), .o_sob(sob1), .o_eob(eob1), .o_mode(omode1));

  zigzag_matrix_buf #(.DATA_W(DW), .NUM_MATRIX(NM), .PX_OUT(4)) dut4 (
    .r_sysclk(clk), .r_srst(rst), .i_mode(mode), .i_we(we), .i_data(din),
    .o_full(full4), .i_re(re4), .o_nempty(nempty4), .o_valid(valid4),
    .o_md(md4), .o_sob(sob4), .o_eob(eob4), .o_mode(omode4));

  typedef struct packed {
    logic [1:0]             m;
    logic [63:0][DW-1:0]    d;
  } blk_t;

  typedef struct packed {
    logic [1:0]    mode;
    logic [5:0]    beat;
    logic [DW-1:0] exp;
  } vec_t;

  blk_t                q [2][$];
  logic [63:0][DW-1:0] part [2];
  int                  pk [2];
  logic [1:0]          pm [2];
  int                  rb [2];
  int                  zz [64];
  int                  nvec = 0, nerr = 0;
  logic [DW-1:0]       cap1 [64];
  logic [4*DW-1:0]     cap4 [16];
  vec_t                vt [14];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference reorder from the raster/zigzag definitions.
  function automatic logic [63:0][DW-1:0] permute(input logic [63:0][DW-1:0] in, input logic [1:0] m);
    logic [63:0][DW-1:0] o;
    int p;
    o = '0;
    for (int k = 0; k < 64; k++) begin
      p = zz[k];
      case (m)
        2'd1:    o[(p % 8) * 8 + p / 8] = in[k];
        2'd2:    o[k] = in[p];
        default: o[p] = in[k];
      endcase
    end
    return o;
  endfunction

  task automatic tick();
    bit   wa [2], ra [2];
    int   px;
    logic [63:0] emd;
    blk_t b;
    for (int d = 0; d < 2; d++) begin
      wa[d] = we && (q[d].size() < NM);
      ra[d] = ((d == 0) ? re1 : re4) && (q[d].size() != 0);
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      px = (d == 0) ? 1 : 4;
      if (ra[d]) begin
        b   = q[d][0];
        emd = '0;
        for (int l = 0; l < px; l++) emd[l*DW +: DW] = b.d[rb[d]*px + l];
        if (d == 0) begin
          chk("valid1", valid1, 1);
          chk("md1", md1, emd);
          chk("sob1", sob1, rb[0] == 0);
          chk("eob1", eob1, rb[0] == 63);
          chk("mode1", omode1, b.m);
          cap1[rb[0]] = md1;
        end else begin
          chk("valid4", valid4, 1);
          chk("md4", md4, emd);
          chk("sob4", sob4, rb[1] == 0);
          chk("eob4", eob4, rb[1] == 15);
          chk("mode4", omode4, b.m);
          cap4[rb[1]] = md4;
        end
        rb[d]++;
        if (rb[d] == 64 / px) begin
          rb[d] = 0;
          void'(q[d].pop_front());
        end
      end else begin
        chk((d == 0) ? "idle_valid1" : "idle_valid4", (d == 0) ? valid1 : valid4, 0);
      end
      if (wa[d]) begin
        if (pk[d] == 0) pm[d] = (mode == 2'd3) ? 2'd0 : mode;
        part[d][pk[d]] = din;
        pk[d]++;
        if (pk[d] == 64) begin
          pk[d] = 0;
          b.m = pm[d];
          b.d = permute(part[d], pm[d]);
          q[d].push_back(b);
        end
      end
      chk((d == 0) ? "full1" : "full4", (d == 0) ? full1 : full4, q[d].size() == NM);
      chk((d == 0) ? "nempty1" : "nempty4", (d == 0) ? nempty1 : nempty4, q[d].size() != 0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; we = 1'b0; re1 = 1'b0; re4 = 1'b0;
    #3;
    for (int d = 0; d < 2; d++) begin
      q[d].delete();
      pk[d] = 0;
      rb[d] = 0;
    end
    chk("rst_full", {full1, full4}, 0);
    chk("rst_nempty", {nempty1, nempty4}, 0);
    chk("rst_valid", {valid1, valid4}, 0);
    chk("rst_sob_eob", {sob1, eob1, sob4, eob4}, 0);
    chk("rst_mode", {omode1, omode4}, 0);
    chk("rst_md1", md1, 0);
    chk("rst_md4", md4, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // kind 0: zigzag stream labelled {row,col} of ZZ[k]; kind 1: raster stream.
  task automatic wr_block(input logic [1:0] m, input int kind, input int n);
    for (int k = 0; k < n; k++) begin
      we   = 1'b1;
      mode = m;
      din  = (kind != 0) ? DW'((k / 8) * 16 + k % 8) : DW'((zz[k] / 8) * 16 + zz[k] % 8);
      tick();
    end
    we = 1'b0;
  endtask

  task automatic rd(input int n1, input int n4);
    for (int i = 0; i < ((n1 > n4) ? n1 : n4); i++) begin
      re1 = (i < n1);
      re4 = (i < n4);
      tick();
    end
    re1 = 1'b0;
    re4 = 1'b0;
  endtask

  initial begin
    int k = 0;
    for (int s = 0; s < 15; s++) begin
      if (s % 2 == 0) begin
        for (int r = (s < 8) ? s : 7; r >= 0 && s - r < 8; r--) begin zz[k] = r * 8 + (s - r); k++; end
      end else begin
        for (int c = (s < 8) ? s : 7; c >= 0 && s - c < 8; c--) begin zz[k] = (s - c) * 8 + c; k++; end
      end
    end

    vt[0]  = '{2'd0, 6'd0,  12'h00};
    vt[1]  = '{2'd0, 6'd1,  12'h01};
    vt[2]  = '{2'd0, 6'd9,  12'h11};
    vt[3]  = '{2'd0, 6'd20, 12'h24};
    vt[4]  = '{2'd0, 6'd63, 12'h77};
    vt[5]  = '{2'd1, 6'd1,  12'h10};
    vt[6]  = '{2'd1, 6'd8,  12'h01};
    vt[7]  = '{2'd1, 6'd20, 12'h42};
    vt[8]  = '{2'd1, 6'd63, 12'h77};
    vt[9]  = '{2'd2, 6'd1,  12'h01};
    vt[10] = '{2'd2, 6'd2,  12'h10};
    vt[11] = '{2'd2, 6'd3,  12'h20};
    vt[12] = '{2'd2, 6'd10, 12'h40};
    vt[13] = '{2'd2, 6'd63, 12'h77};

    do_reset();

    for (int m = 0; m < 3; m++) begin
      wr_block(2'(m), (m == 2) ? 1 : 0, 64);
      rd(64, 16);
      for (int i = 0; i < 14; i++) begin
        if (vt[i].mode == 2'(m)) chk($sformatf("tbl_m%0d_b%0d", m, vt[i].beat), cap1[vt[i].beat], vt[i].exp);
      end
      if (m == 0) chk("px4_beat0", cap4[0], 48'h003002001000);
    end

    wr_block(2'd0, 0, 64);
    wr_block(2'd1, 0, 64);
    wr_block(2'd2, 1, 64);
    wr_block(2'd0, 0, 64);
    chk("full_after_256", {full1, full4}, 2'b11);
    we = 1'b1; din = 12'hABC; mode = 2'd1;
    tick();
    we = 1'b0;
    rd(64, 16);
    chk("full_fell", {full1, full4}, 2'b00);
    rd(192, 48);
    chk("drained", {nempty1, nempty4}, 2'b00);

    wr_block(2'd0, 0, 64);
    for (int i = 0; i < 64; i++) begin
      we = 1'b1; mode = 2'd1; din = DW'($urandom);
      re1 = 1'b1; re4 = (i >= 48);
      tick();
    end
    we = 1'b0; re1 = 1'b0; re4 = 1'b0;
    chk("nempty_sim", {nempty1, nempty4}, 2'b11);
    rd(64, 16);

    wr_block(2'd1, 0, 20);
    do_reset();
    wr_block(2'd2, 1, 64);
    rd(64, 16);
    chk("post_rst_beat3", cap1[3], 12'h20);

    for (int i = 0; i < 3000; i++) begin
      we   = ($urandom_range(0, 3) != 0);
      mode = 2'($urandom_range(0, 2));
      din  = DW'($urandom);
      re1  = ($urandom_range(0, 2) != 0);
      re4  = ($urandom_range(0, 3) == 0);
      tick();
    end
    we = 1'b0;
    rd(256, 64);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
